// File: rtl/countdown_seconds_ctrl_if.sv
// Control/status bundle between the seconds countdown and its controller.
// The countdown takes the slave side; whoever drives load/start/pause/tick takes the master side.
interface countdown_seconds_ctrl_if;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic       start;
    logic       pause;
    logic       tick_1s;
    logic       timer_en;
    logic [3:0] tens_out;
    logic [3:0] ones_out;
    logic       running;
    logic       expired;
    logic       done;

    modport master (
        output load, load_tens, load_ones, start, pause, tick_1s,
        input  timer_en, tens_out, ones_out, running, expired, done
    );

    modport slave (
        input  load, load_tens, load_ones, start, pause, tick_1s,
        output timer_en, tens_out, ones_out, running, expired, done
    );
endinterface

// File: rtl/countdown_seconds_ctrl.sv
// Two-digit BCD seconds countdown paced by an external 1 Hz tick, with pause/resume,
// optional auto-reload and a one-cycle expiry pulse. Every output comes straight from a flop.
module countdown_seconds_ctrl #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    countdown_seconds_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] pre_tens_q, pre_tens_d;
    logic [3:0] pre_ones_q, pre_ones_d;
    logic       expired_q, expired_d;
    logic       timer_en_q, running_q, done_q;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
        return (digit > 4'd9) ? 4'd9 : digit;
    endfunction

    logic count_is_one;
    logic preset_is_zero;
    assign count_is_one   = (tens_q == 4'd0) && (ones_q == 4'd1);
    assign preset_is_zero = (pre_tens_q == 4'd0) && (pre_ones_q == 4'd0);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        pre_tens_d = pre_tens_q;
        pre_ones_d = pre_ones_q;
        expired_d  = 1'b0;

        if (bus.load) begin
            tens_d     = clamp_bcd(bus.load_tens);
            ones_d     = clamp_bcd(bus.load_ones);
            pre_tens_d = clamp_bcd(bus.load_tens);
            pre_ones_d = clamp_bcd(bus.load_ones);
            state_d    = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!bus.pause && bus.start) begin
                        if (tens_q == 4'd0 && ones_q == 4'd0) begin
                            state_d   = ST_DONE;
                            expired_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSED;
                    end else if (bus.tick_1s) begin
                        if (count_is_one) begin
                            expired_d = 1'b1;
                            // A zero preset would reload into an instant re-expiry, so stop instead.
                            if (AUTO_RELOAD && !preset_is_zero) begin
                                tens_d = pre_tens_q;
                                ones_d = pre_ones_q;
                            end else begin
                                tens_d  = 4'd0;
                                ones_d  = 4'd0;
                                state_d = ST_DONE;
                            end
                        end else if (ones_q == 4'd0) begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end else begin
                            ones_d = ones_q - 4'd1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!bus.pause && bus.start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Status flags are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q    <= ST_IDLE;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            pre_tens_q <= 4'd0;
            pre_ones_q <= 4'd0;
            expired_q  <= 1'b0;
            timer_en_q <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            pre_tens_q <= pre_tens_d;
            pre_ones_q <= pre_ones_d;
            expired_q  <= expired_d;
            timer_en_q <= (state_d == ST_RUN);
            running_q  <= (state_d == ST_RUN);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign bus.timer_en = timer_en_q;
    assign bus.tens_out = tens_q;
    assign bus.ones_out = ones_q;
    assign bus.running  = running_q;
    assign bus.expired  = expired_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_countdown_seconds_ctrl.sv
// Bench for countdown_seconds_ctrl: one instance per AUTO_RELOAD setting, both compared every
// cycle against an integer-seconds reference model, plus a vector table and hand sequences.
module tb_countdown_seconds_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    logic       ld = 1'b0, st = 1'b0, pa = 1'b0, tk = 1'b0;
    logic [3:0] lt = 4'd0, lo = 4'd0;

    countdown_seconds_ctrl_if if0 ();
    countdown_seconds_ctrl_if if1 ();

    assign if0.load = ld;  assign if0.load_tens = lt;  assign if0.load_ones = lo;
    assign if0.start = st; assign if0.pause = pa;      assign if0.tick_1s = tk;
    assign if1.load = ld;  assign if1.load_tens = lt;  assign if1.load_ones = lo;
    assign if1.start = st; assign if1.pause = pa;      assign if1.tick_1s = tk;

    countdown_seconds_ctrl #(.AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    countdown_seconds_ctrl #(.AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: count held as plain seconds 0..99, mode as a small label.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    typedef struct {
        int secs;
        int preset;
        int mode;
        bit expired;
    } model_t;

    model_t m0, m1;

    function automatic int clamp9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    function automatic model_t model_next(input model_t m, input bit reload);
        model_t n = m;
        n.expired = 1'b0;
        if (!rst) begin
            n.secs = 0; n.preset = 0; n.mode = M_IDLE;
        end else if (ld) begin
            n.secs   = clamp9(int'(lt)) * 10 + clamp9(int'(lo));
            n.preset = n.secs;
            n.mode   = M_IDLE;
        end else if (m.mode == M_IDLE) begin
            if (!pa && st) begin
                if (m.secs == 0) begin n.mode = M_DONE; n.expired = 1'b1; end
                else n.mode = M_RUN;
            end
        end else if (m.mode == M_RUN) begin
            if (pa) n.mode = M_PAUSED;
            else if (tk) begin
                n.secs = m.secs - 1;
                if (n.secs == 0) begin
                    n.expired = 1'b1;
                    if (reload && m.preset != 0) n.secs = m.preset;
                    else n.mode = M_DONE;
                end
            end
        end else if (m.mode == M_PAUSED) begin
            if (!pa && st) n.mode = M_RUN;
        end
        return n;
    endfunction

    function automatic logic [11:0] pack(input logic te, input logic [3:0] t, input logic [3:0] o,
                                         input logic r, input logic e, input logic d);
        return {te, t, o, r, e, d};
    endfunction

    function automatic logic [11:0] model_out(input model_t m);
        return pack(m.mode == M_RUN, 4'(m.secs / 10), 4'(m.secs % 10),
                    m.mode == M_RUN, m.expired, m.mode == M_DONE);
    endfunction

    function automatic logic [11:0] dut0_out();
        return pack(if0.timer_en, if0.tens_out, if0.ones_out, if0.running, if0.expired, if0.done);
    endfunction

    function automatic logic [11:0] dut1_out();
        return pack(if1.timer_en, if1.tens_out, if1.ones_out, if1.running, if1.expired, if1.done);
    endfunction

    task automatic drive(input logic l, input logic [3:0] t, input logic [3:0] o,
                         input logic s, input logic p, input logic k);
        ld = l; lt = t; lo = o; st = s; pa = p; tk = k;
    endtask

    // One clock: the model sees the same inputs the DUT latched, outputs are sampled 1 ns later.
    task automatic cycle(input string tag);
        @(posedge clk);
        m0 = model_next(m0, 1'b0);
        m1 = model_next(m1, 1'b1);
        #1;
        check({tag, "/ar0"}, 32'(dut0_out()), 32'(model_out(m0)));
        check({tag, "/ar1"}, 32'(dut1_out()), 32'(model_out(m1)));
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            cycle(tag);
        end
    endtask

    typedef struct {
        bit       ld;
        bit [3:0] lt, lo;
        bit       st, pa, tk;
        bit [3:0] et, eo;
        bit       er, ee, ed;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    initial begin
        m0 = '{secs: 0, preset: 0, mode: M_IDLE, expired: 1'b0};
        m1 = m0;

        // ld lt lo st pa tk | tens ones run exp done  (AUTO_RELOAD=0 instance)
        vecs = '{
            '{1, 4'h0, 4'h3, 0, 0, 0, 4'd0, 4'd3, 0, 0, 0},
            '{0, 4'h0, 4'h0, 1, 0, 0, 4'd0, 4'd3, 1, 0, 0},
            '{0, 4'h0, 4'h0, 0, 0, 0, 4'd0, 4'd3, 1, 0, 0},
            '{0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd2, 1, 0, 0},
            '{0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd1, 1, 0, 0},
            '{0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd0, 0, 1, 1},
            '{0, 4'h0, 4'h0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 1},
            '{0, 4'h0, 4'h0, 1, 0, 1, 4'd0, 4'd0, 0, 0, 1},
            '{1, 4'h1, 4'h0, 0, 0, 0, 4'd1, 4'd0, 0, 0, 0},
            '{0, 4'h0, 4'h0, 1, 0, 0, 4'd1, 4'd0, 1, 0, 0},
            '{0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd9, 1, 0, 0},
            '{1, 4'hC, 4'hA, 0, 0, 0, 4'd9, 4'd9, 0, 0, 0},
            '{1, 4'h0, 4'h0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0},
            '{0, 4'h0, 4'h0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 1},
            '{0, 4'h0, 4'h0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 1},
            '{1, 4'h0, 4'h5, 0, 0, 0, 4'd0, 4'd5, 0, 0, 0},
            '{0, 4'h0, 4'h0, 1, 0, 0, 4'd0, 4'd5, 1, 0, 0},
            '{0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd4, 1, 0, 0},
            '{0, 4'h0, 4'h0, 0, 1, 1, 4'd0, 4'd4, 0, 0, 0},
            '{0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd4, 0, 0, 0},
            '{0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd4, 0, 0, 0},
            '{0, 4'h0, 4'h0, 1, 0, 0, 4'd0, 4'd4, 1, 0, 0},
            '{0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd3, 1, 0, 0},
            '{0, 4'h0, 4'h0, 1, 1, 0, 4'd0, 4'd3, 0, 0, 0},
            '{0, 4'h0, 4'h0, 0, 1, 0, 4'd0, 4'd3, 0, 0, 0},
            '{0, 4'h0, 4'h0, 1, 0, 0, 4'd0, 4'd3, 1, 0, 0},
            '{0, 4'h0, 4'h0, 1, 0, 0, 4'd0, 4'd3, 1, 0, 0}
        };

        // Reset held for 3 clocks with random inputs on the pins.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            cycle("reset");
        end
        check("reset_state0", 32'(dut0_out()), 32'(12'h000));
        check("reset_state1", 32'(dut1_out()), 32'(12'h000));
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle("post_reset");

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].ld, vecs[i].lt, vecs[i].lo, vecs[i].st, vecs[i].pa, vecs[i].tk);
            cycle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_const", i), 32'(dut0_out()),
                  32'(pack(vecs[i].er, vecs[i].et, vecs[i].eo, vecs[i].er, vecs[i].ee, vecs[i].ed)));
        end

        // Ticks 5 clocks apart from 03; expiry lands exactly on the third tick.
        drive(1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0); cycle("seq3_load");
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0); cycle("seq3_start");
        for (int k = 0; k < 3; k++) begin
            idle_cycles(4, "seq3_gap");
            drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); cycle("seq3_tick");
            check($sformatf("seq3_ones%0d", k), 32'(if0.ones_out), 32'(2 - k));
        end
        check("seq3_expired", 32'({if0.expired, if0.done, if0.timer_en}), 32'(3'b110));
        idle_cycles(1, "seq3_after");
        check("seq3_expired_once", 32'(if0.expired), 32'(0));

        // Auto-reload from 02: 01, 02 with expiry, 01, 02 with expiry; running never drops.
        drive(1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0); cycle("ar_load");
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0); cycle("ar_start");
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 4; g++) begin
                idle_cycles(1, "ar_gap");
                check("ar_running_gap", 32'(if1.running), 32'(1));
            end
            drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); cycle("ar_tick");
            check($sformatf("ar_tick%0d", k), 32'({if1.ones_out, if1.expired, if1.running}),
                  32'({(k % 2 == 0) ? 4'd1 : 4'd2, (k % 2 == 1), 1'b1}));
        end

        // Reset in the middle of a count.
        drive(1'b1, 4'd4, 4'd2, 1'b0, 1'b0, 1'b0); cycle("mid_load");
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0); cycle("mid_start");
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); cycle("mid_tick");
        rst = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); cycle("mid_reset");
        check("mid_reset_state", 32'(dut0_out()), 32'(12'h000));
        rst = 1'b1;

        // Random traffic against the model; start and tick are kept in separate cycles.
        for (int i = 0; i < 4000; i++) begin
            logic r_ld, r_st, r_pa, r_tk;
            r_ld = ($urandom_range(0, 39) == 0);
            r_st = ($urandom_range(0, 7) == 0);
            r_pa = ($urandom_range(0, 11) == 0);
            r_tk = !r_st && ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 499) != 0);
            drive(r_ld, 4'($urandom), 4'($urandom), r_st, r_pa, r_tk);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
